slave_port_ctrl: RTL and testbench
==================================

Name: slave_port_ctrl

Overview:
Bus-side front end for the slave memory. Receives bit-serial transactions (mode, address, write data) from the system bus and converts them to single-cycle parallel wen/ren accesses on the memory. Captures the combinational read data and returns it to the bus bit-serially. Sits directly upstream of the slave memory, one instance per slave.

Parameters:
ADDR_WIDTH, 12, memory address width; also the number of serial address bits per transaction
DATA_WIDTH, 8, memory data width; also the number of serial data bits per transaction
TIMEOUT_CYCLES, 16, stall limit used only when SLAVE_TIMEOUT_EN is defined

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
mvalid  input  1  master valid; qualifies handshake and each serial bit
mode  input  1  1=write, 0=read; sampled on handshake cycle only
mwdata  input  1  serial address/write-data bit, LSB first
sready  output  1  slave idle and able to accept a new transaction
svalid  output  1  srdata carries a valid read-data bit
srdata  output  1  serial read-data bit, LSB first
timeout  output  1  one-cycle pulse on transaction abort (optional feature)
mem_addr  output  ADDR_WIDTH  address to memory
mem_wdata  output  DATA_WIDTH  write data to memory
mem_wen  output  1  memory write enable, one-cycle pulse
mem_ren  output  1  memory read enable, one-cycle pulse
mem_rdata  input  DATA_WIDTH  memory read data, combinationally valid while mem_ren=1

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; sready, svalid, srdata, timeout, mem_wen, mem_ren = 0; mem_addr, mem_wdata, shift registers, bit counter = 0.
- All outputs registered. sready next-value = (next_state==IDLE); rises on the first clk edge after reset release.
- States: IDLE, ADDR, WDATA, WRITE, READ, RDATA.
- IDLE: handshake = mvalid & sready. On handshake, latch mode, clear counter, go ADDR. No address bit is taken in the handshake cycle.
- ADDR: each cycle with mvalid=1, shift mwdata into the address register LSB first and increment counter. mvalid=0 stalls: no shift, no count. After ADDR_WIDTH bits, go WDATA (write) or READ (read). Counter is $clog2 of the max width, resets to 0 per phase.
- WDATA: same shifting/stall rules for DATA_WIDTH bits into mem_wdata, then go WRITE.
- WRITE: mem_wen=1 for exactly one cycle with mem_addr/mem_wdata stable, then IDLE.
- READ: mem_ren=1 for exactly one cycle. mem_rdata is captured into the output shift register on that edge, then go RDATA.
- RDATA: svalid=1 for exactly DATA_WIDTH consecutive cycles. srdata = captured bit 0, 1, … No backpressure. Then IDLE with svalid=0.
- Latency from handshake cycle (cycle 0):
  - Write, no stalls: mem_wen at cycle ADDR_WIDTH+DATA_WIDTH+1.
  - Read, no stalls: mem_ren at cycle ADDR_WIDTH+1; first svalid at ADDR_WIDTH+2; last svalid at ADDR_WIDTH+DATA_WIDTH+1.
- sready=0 in every state except IDLE. mvalid outside IDLE/ADDR/WDATA is ignored. mode is ignored except on the handshake cycle.
- Back-to-back: sready returns to 1 the cycle after WRITE or the last RDATA bit, so a new handshake can occur there.
- mem_addr and mem_wdata hold their last values in IDLE. mem_wen and mem_ren are never high simultaneously.
- Reset mid-transaction aborts immediately with no memory access; the partial transaction is discarded.

Optional Feature:
SLAVE_TIMEOUT_EN.
- Defined: in ADDR or WDATA, a stall counter increments on each mvalid=0 cycle and clears on mvalid=1. When it reaches TIMEOUT_CYCLES, go IDLE with no memory access and pulse timeout=1 for one cycle.
- Not defined: no stall counter; timeout is tied to 0; stalls are unbounded.

Test Plan:
1. Write with ADDR_WIDTH=12, DATA_WIDTH=8: handshake mode=1, addr 0x123 then data 0xA5 serially, no stalls -> mem_wen single pulse at cycle 21 with mem_addr=0x123, mem_wdata=0xA5.
2. Read of 0x123 with memory returning 0xA5 -> mem_ren at cycle 13; svalid high cycles 14–21; srdata sequence 1,0,1,0,0,1,0,1.
3. Write 0x3C to 0x0FF with mvalid low for 5 cycles after address bit 3 -> mem_wen delayed exactly 5 cycles to cycle 26; data correct.
4. Back-to-back write then read of 0x0FF -> second handshake accepted the cycle after mem_wen; read returns 0x3C.
5. Assert rstn low mid-WDATA -> all outputs 0 immediately; no mem_wen; sready=1 one edge after release; next transaction completes normally.
6. With SLAVE_TIMEOUT_EN, TIMEOUT_CYCLES=16: stall 16 cycles in ADDR -> timeout pulse, no mem_ren/mem_wen, sready=1 next cycle. Without the macro: same stall, then resume -> transaction completes normally.

Source files
------------

// File: rtl/slave_port_ctrl.sv
// Bus-side front end for the slave memory: serial (mode, address, data) in, single-cycle wen/ren out, serial read data back.
// Optional build macro SLAVE_TIMEOUT_EN adds a stall counter that aborts stuck transactions.
module slave_port_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mvalid,
    input  logic                  mode,
    input  logic                  mwdata,
    output logic                  sready,
    output logic                  svalid,
    output logic                  srdata,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW        = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4,
        RDATA = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  is_write;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic                  addr_done;
    logic                  data_done;
    logic                  in_phase;
    logic                  stall_hit;

    assign addr_done = (bit_cnt == CW'(ADDR_WIDTH - 1));
    assign data_done = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign in_phase  = (state == ADDR) || (state == WDATA);

`ifdef SLAVE_TIMEOUT_EN
    localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [SW-1:0] stall_cnt;

    // Fires on the stall cycle that would make the consecutive-stall count reach the limit.
    assign stall_hit = in_phase && !mvalid && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= stall_hit;
            if (in_phase && !mvalid && !stall_hit) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`else
    assign stall_hit = 1'b0;
    // Stall limit has no effect in this build; timeout never fires.
    assign timeout   = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // Handshake: a transaction starts on a cycle with mvalid=1 and sready=1; afterwards
    // mvalid=1 qualifies each serial bit and mvalid=0 stalls. There is no read backpressure.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mvalid && sready) begin
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (stall_hit) begin
                    state_nx = IDLE;
                end else if (mvalid && addr_done) begin
                    state_nx = is_write ? WDATA : READ;
                end
            end
            WDATA: begin
                if (stall_hit) begin
                    state_nx = IDLE;
                end else if (mvalid && data_done) begin
                    state_nx = WRITE;
                end
            end
            WRITE:   state_nx = IDLE;
            READ:    state_nx = RDATA;
            RDATA: begin
                if (data_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            bit_cnt   <= '0;
            rd_shift  <= '0;
            sready    <= 1'b0;
            svalid    <= 1'b0;
            srdata    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
        end else begin
            state   <= state_nx;
            sready  <= (state_nx == IDLE);
            mem_wen <= (state_nx == WRITE);
            mem_ren <= (state_nx == READ);
            case (state)
                IDLE: begin
                    if (state_nx == ADDR) begin
                        is_write <= mode;
                        bit_cnt  <= '0;
                    end
                end
                ADDR: begin
                    if (mvalid) begin
                        mem_addr <= {mwdata, mem_addr[ADDR_WIDTH-1:1]};
                        bit_cnt  <= addr_done ? '0 : bit_cnt + 1'b1;
                    end
                end
                WDATA: begin
                    if (mvalid) begin
                        mem_wdata <= {mwdata, mem_wdata[DATA_WIDTH-1:1]};
                        bit_cnt   <= data_done ? '0 : bit_cnt + 1'b1;
                    end
                end
                READ: begin
                    // Read data is only valid during mem_ren, so take it all now.
                    rd_shift <= mem_rdata >> 1;
                    srdata   <= mem_rdata[0];
                    svalid   <= 1'b1;
                    bit_cnt  <= '0;
                end
                RDATA: begin
                    if (data_done) begin
                        svalid  <= 1'b0;
                        srdata  <= 1'b0;
                        bit_cnt <= '0;
                    end else begin
                        srdata   <= rd_shift[0];
                        rd_shift <= rd_shift >> 1;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_port_ctrl.sv
// Bench for slave_port_ctrl: transaction-level expected-output schedule plus latency/data literals.
module tb_slave_port_ctrl;

    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          mvalid;
    logic          mode;
    logic          mwdata;
    logic          sready;
    logic          svalid;
    logic          srdata;
    logic          timeout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata;

    slave_port_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mvalid   (mvalid),
        .mode     (mode),
        .mwdata   (mwdata),
        .sready   (sready),
        .svalid   (svalid),
        .srdata   (srdata),
        .timeout  (timeout),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wen  (mem_wen),
        .mem_ren  (mem_ren),
        .mem_rdata(mem_rdata)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory behind the port
    logic [DW-1:0] tb_mem[1 << AW];
    always @(posedge clk) if (mem_wen) tb_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr];

    // model state
    typedef struct packed {
        logic          sready;
        logic          svalid;
        logic          srdata;
        logic          wen;
        logic          ren;
        logic          tmo;
        logic          chk_a;
        logic          chk_d;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem[1 << AW];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          a_known;
    logic          d_known;
    logic          tmo_pending;
    int            hs_cyc;

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e        = '0;
        e.sready = 1'b1;
        e.tmo    = tmo_pending;
        e.chk_a  = a_known;
        e.addr   = m_addr;
        e.chk_d  = d_known;
        e.wdata  = m_wdata;
        return e;
    endfunction

    function automatic exp_t busy_e();
        exp_t e;
        e       = '0;
        e.chk_d = d_known;
        e.wdata = m_wdata;
        return e;
    endfunction

    function automatic exp_t phase_e(input int i, input logic [AW-1:0] a);
        exp_t e;
        e = busy_e();
        if (i >= AW) begin
            e.chk_a = 1'b1;
            e.addr  = a;
            e.chk_d = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t rst_e();
        exp_t e;
        e       = '0;
        e.chk_a = 1'b1;
        e.chk_d = 1'b1;
        return e;
    endfunction

    // driver tasks: called at posedge+1, drive one cycle and queue its expected outputs
    task automatic step(input logic v, input logic m, input logic d, input exp_t e);
        mvalid = v;
        mode   = m;
        mwdata = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e           = idle_e();
            tmo_pending = 1'b0;
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
        end
    endtask

    task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int stall_at, input int stall_len, input int abort_at);
        exp_t e;
        logic b;
        int   nbits;
        nbits       = wr ? AW + DW : AW;
        e           = idle_e();
        tmo_pending = 1'b0;
        hs_cyc      = cyc;
        step(1'b1, wr, 1'($urandom_range(0, 1)), e);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) return;
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    e = phase_e(i, a);
                    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
`ifdef SLAVE_TIMEOUT_EN
                    if (s + 1 == TMO) begin
                        tmo_pending = 1'b1;
                        if (i < AW) a_known = 1'b0;
                        else d_known = 1'b0;
                        return;
                    end
`endif
                end
            end
            e = phase_e(i, a);
            if (i < AW) b = a[i];
            else b = d[i-AW];
            step(1'b1, 1'($urandom_range(0, 1)), b, e);
            if (i == AW - 1) begin
                m_addr  = a;
                a_known = 1'b1;
            end
            if (i >= AW) d_known = 1'b0;
        end
        e       = busy_e();
        e.chk_a = 1'b1;
        e.addr  = a;
        if (wr) begin
            e.wen   = 1'b1;
            e.chk_d = 1'b1;
            e.wdata = d;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
            m_wdata    = d;
            d_known    = 1'b1;
            ref_mem[a] = d;
        end else begin
            e.ren = 1'b1;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
            for (int k = 0; k < DW; k++) begin
                e        = busy_e();
                e.chk_a  = 1'b1;
                e.addr   = a;
                e.svalid = 1'b1;
                e.srdata = ref_mem[a][k];
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
            end
        end
    endtask

    // scoreboard compare + event monitor
    exp_t          ce;
    int            wen_cyc, ren_cyc, first_sv, last_sv, tmo_cyc;
    logic [AW-1:0] wen_addr;
    logic [DW-1:0] wen_data;
    logic [DW-1:0] rd_bits;
    logic          sv_prev = 1'b0;

    task automatic clr_mon();
        wen_cyc  = -1;
        ren_cyc  = -1;
        first_sv = -1;
        last_sv  = -1;
        tmo_cyc  = -1;
        rd_bits  = '0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk1("sready", sready, ce.sready);
            chk1("svalid", svalid, ce.svalid);
            if (ce.svalid) chk1("srdata", srdata, ce.srdata);
            chk1("mem_wen", mem_wen, ce.wen);
            chk1("mem_ren", mem_ren, ce.ren);
            chk1("timeout", timeout, ce.tmo);
            if (ce.chk_a) chkw("mem_addr", 32'(mem_addr), 32'(ce.addr));
            if (ce.chk_d) chkw("mem_wdata", 32'(mem_wdata), 32'(ce.wdata));
        end
        if (mem_wen) begin
            wen_cyc  = cyc;
            wen_addr = mem_addr;
            wen_data = mem_wdata;
        end
        if (mem_ren) ren_cyc = cyc;
        if (timeout) tmo_cyc = cyc;
        if (svalid) begin
            if (!sv_prev) first_sv = cyc;
            last_sv = cyc;
            rd_bits = {srdata, rd_bits[DW-1:1]};
        end
        sv_prev = svalid;
    end

    task automatic chk_reset(input string name);
        chk1({name, "_sready"}, sready, 1'b0);
        chk1({name, "_svalid"}, svalid, 1'b0);
        chk1({name, "_srdata"}, srdata, 1'b0);
        chk1({name, "_timeout"}, timeout, 1'b0);
        chk1({name, "_wen"}, mem_wen, 1'b0);
        chk1({name, "_ren"}, mem_ren, 1'b0);
        chkw({name, "_addr"}, 32'(mem_addr), 32'h0);
        chkw({name, "_wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    task automatic release_reset();
        rstn = 1'b1;
        step(1'b0, 1'b0, 1'b0, rst_e());
        m_addr      = '0;
        m_wdata     = '0;
        a_known     = 1'b1;
        d_known     = 1'b1;
        tmo_pending = 1'b0;
    endtask

    int w_cyc;

    initial begin
        for (int k = 0; k < (1 << AW); k++) begin
            tb_mem[k]  = '0;
            ref_mem[k] = '0;
        end
        rstn   = 1'b0;
        mvalid = 1'b0;
        mode   = 1'b0;
        mwdata = 1'b0;
        clr_mon();
        #2;
        chk_reset("por");
        @(posedge clk);
        #1;
        release_reset();
        chk1("sready_after_release", sready, 1'b1);
        idle(2);

        // 1: plain write
        clr_mon();
        do_xfer(1'b1, 12'h123, 8'hA5, -1, 0, -1);
        idle(1);
        chkw("t1_wen_latency", 32'(wen_cyc - hs_cyc), 32'd21);
        chkw("t1_wen_addr", 32'(wen_addr), 32'h123);
        chkw("t1_wen_data", 32'(wen_data), 32'hA5);

        // 2: plain read
        clr_mon();
        do_xfer(1'b0, 12'h123, 8'h00, -1, 0, -1);
        idle(1);
        chkw("t2_ren_latency", 32'(ren_cyc - hs_cyc), 32'd13);
        chkw("t2_first_svalid", 32'(first_sv - hs_cyc), 32'd14);
        chkw("t2_last_svalid", 32'(last_sv - hs_cyc), 32'd21);
        chkw("t2_read_bits", 32'(rd_bits), 32'hA5);

        // 3: write with 5-cycle stall in the address phase
        clr_mon();
        do_xfer(1'b1, 12'h0FF, 8'h3C, 4, 5, -1);
        idle(1);
        chkw("t3_wen_latency", 32'(wen_cyc - hs_cyc), 32'd26);
        chkw("t3_wen_data", 32'(wen_data), 32'h3C);

        // 4: back-to-back write then read
        clr_mon();
        do_xfer(1'b1, 12'h0FF, 8'h3C, -1, 0, -1);
        w_cyc = wen_cyc;
        do_xfer(1'b0, 12'h0FF, 8'h00, -1, 0, -1);
        idle(1);
        chkw("t4_b2b_handshake", 32'(hs_cyc - w_cyc), 32'd1);
        chkw("t4_read_bits", 32'(rd_bits), 32'h3C);

        // address/data extremes, stall in data phase, read of untouched location
        clr_mon();
        do_xfer(1'b1, 12'hFFF, 8'h81, AW + 2, 3, -1);
        do_xfer(1'b0, 12'hFFF, 8'h00, -1, 0, -1);
        chkw("edge_read_fff", 32'(rd_bits), 32'h81);
        do_xfer(1'b0, 12'h000, 8'h00, -1, 0, -1);
        chkw("edge_read_000", 32'(rd_bits), 32'h00);
        idle(1);

        // 5: reset in the middle of the data phase
        clr_mon();
        do_xfer(1'b1, 12'h456, 8'h77, -1, 0, AW + 3);
        rstn = 1'b0;
        #1;
        chk_reset("mid_rst");
        step(1'b1, 1'b1, 1'b1, rst_e());
        step(1'b1, 1'b1, 1'b1, rst_e());
        release_reset();
        chk1("t5_sready_post_release", sready, 1'b1);
        chkw("t5_no_wen", 32'(wen_cyc), 32'hFFFF_FFFF);
        do_xfer(1'b1, 12'h456, 8'h77, -1, 0, -1);
        do_xfer(1'b0, 12'h456, 8'h00, -1, 0, -1);
        idle(1);
        chkw("t5_recover_read", 32'(rd_bits), 32'h77);

        // 6: long stall in the address phase
        clr_mon();
        do_xfer(1'b0, 12'h0FF, 8'h00, 5, 20, -1);
        idle(2);
`ifdef SLAVE_TIMEOUT_EN
        chkw("t6_timeout_cycle", 32'(tmo_cyc - hs_cyc), 32'd22);
        chkw("t6_no_ren", 32'(ren_cyc), 32'hFFFF_FFFF);
        do_xfer(1'b0, 12'h0FF, 8'h00, -1, 0, -1);
        idle(1);
        chkw("t6_after_timeout_read", 32'(rd_bits), 32'h3C);
`else
        chkw("t6_no_timeout", 32'(tmo_cyc), 32'hFFFF_FFFF);
        chkw("t6_ren_latency", 32'(ren_cyc - hs_cyc), 32'd33);
        chkw("t6_read_bits", 32'(rd_bits), 32'h3C);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
